// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Round-robin pointer arithmetic lives here for reuse by other schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  // Modulo increment with explicit wrap; n need not be a power of two.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit at or after ptr.
// Rotates the request vector, priority-encodes, then unrotates.
module fifo_wr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;
  int           src;
  int           off;
  int           sum;

  // Rotate so ptr lands at bit 0, take lowest set bit, map back.
  always_comb begin
    rot = '0;
    src = 0;
    off = 0;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      src = i + int'(ptr);
      if (src >= N) src = src - N;
      rot[i] = req[src];
    end
    found = |rot;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    sum = int'(ptr) + off;
    if (sum >= N) sum = sum - N;
    idx = IW'(sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locking round-robin arbiter for a shared FIFO write port.
// Holds a grant until last, MAX_BURST beats or an idle timeout.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = 8,
  parameter  int MAX_BURST    = 8,
  parameter  int IDLE_TIMEOUT = 4,
  localparam int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);
  localparam logic [TW-1:0] IDLE_MAX = TW'(IDLE_TIMEOUT);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [TW-1:0]         idle_q, idle_d;

  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  xfer;
  logic [BW-1:0]         beat_inc;
  logic [TW-1:0]         idle_inc;

  fifo_wr_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Route the current grantee's valid/last/data onto shared lines.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(grant_q) == i) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer     = (state_q == ARB_BURST) & sel_valid & ~fifo_full;
  assign beat_inc = beat_q + BW'(1);
  assign idle_inc = idle_q + TW'(1);
  assign grant_id = grant_q;

  // Output mux; reset gates everything so no partial word escapes.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    busy       = 1'b0;
    if (!rst && state_q == ARB_BURST) begin
      busy       = 1'b1;
      fifo_wr_en = xfer;
      if (xfer) fifo_din = sel_data;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (int'(grant_q) == i) req_ready[i] = ~fifo_full;
      end
    end
  end

  // Arbitration and burst bookkeeping; full with valid is a pure stall.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_BURST;
          beat_d  = '0;
          idle_d  = '0;
        end
      end
      ARB_BURST: begin
        if (xfer) begin
          beat_d = beat_inc;
          idle_d = '0;
          if (sel_last || beat_inc == BEAT_MAX) begin
            state_d = ARB_IDLE;
          end
        end else if (sel_valid) begin
          idle_d = '0;
        end else begin
          idle_d = idle_inc;
          if (idle_inc == IDLE_MAX) begin
            state_d = ARB_IDLE;
          end
        end
        if (state_d == ARB_IDLE) begin
          beat_d = '0;
          idle_d = '0;
          ptr_d  = ID_WIDTH'(rr_next(int'(grant_q), NUM_REQ));
        end
      end
    endcase
  end

  // State, pointer, grant and counters with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      beat_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table plus
// hand sequences, with a scoreboard of expected FIFO words.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ      (N),
    .DATA_WIDTH   (DW),
    .MAX_BURST    (8),
    .IDLE_TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  typedef struct {
    logic       r;
    logic [3:0] v;
    logic [3:0] l;
    logic       f;
    logic       we;
    logic [3:0] rdy;
    logic       bz;
    int         gid;
  } vec_t;

  vec_t          tv[14];
  int            passed = 0;
  int            total  = 0;
  logic [DW-1:0] sbq[$];
  int            glog[$];
  int            llog[$];
  int            rem[N];
  int            cnt[N];
  bit            uselast[N];
  bit            prod_en = 1'b0;
  logic          s_wr, s_busy;
  logic          p_busy = 1'b0;
  logic [DW-1:0] s_din;
  logic [N-1:0]  s_ready;
  int            s_gid;
  int            blen = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l,
                              logic f, logic we, logic [3:0] rdy,
                              logic bz, int gid);
    vec_t t;
    t.r = r; t.v = v; t.l = l; t.f = f;
    t.we = we; t.rdy = rdy; t.bz = bz; t.gid = gid;
    return t;
  endfunction

  function automatic logic [DW-1:0] word(int i, int k);
    return DW'(i * 64 + k);
  endfunction

  function automatic bit alldone();
    bit d = 1'b1;
    for (int i = 0; i < N; i++) if (rem[i] > 0) d = 1'b0;
    return d;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rem[i] > 0;
      req_last[i]  = uselast[i] && rem[i] == 1;
      req_data[i*DW +: DW] = word(i, cnt[i]);
    end
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    s_wr    = fifo_wr_en;
    s_din   = fifo_din;
    s_ready = req_ready;
    s_busy  = busy;
    s_gid   = int'(grant_id);
    acc     = req_valid & req_ready;
    if (s_wr) begin
      if (sbq.size() == 0) chk("sb_extra_write", sbq.size(), 1);
      else chk("sb_din", int'(s_din), int'(sbq.pop_front()));
    end
    if (s_busy && !p_busy) begin
      glog.push_back(s_gid);
      blen = 0;
    end
    if (s_wr) blen++;
    if (!s_busy && p_busy) llog.push_back(blen);
    p_busy = s_busy;
    @(posedge clk);
    #1;
    if (prod_en) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          rem[i]--;
          cnt[i]++;
        end
      end
      drive();
    end
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(alldone() && !s_busy) && n < bound);
    chk("run_bound", int'(alldone() && !s_busy), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      cnt[i] = 0;
      uselast[i] = 1'b0;
    end
    drive();
    tick();
    tick();
    rst = 1'b0;
    glog.delete();
    llog.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = mk(1, 4'hF, 4'hF, 0, 0, 4'h0, 0, 0);
    tv[1]  = mk(1, 4'hF, 4'hF, 0, 0, 4'h0, 0, 0);
    tv[2]  = mk(1, 4'hF, 4'hF, 0, 0, 4'h0, 0, 0);
    tv[3]  = mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 0);
    tv[4]  = mk(0, 4'hF, 4'hF, 0, 1, 4'h1, 1, 0);
    tv[5]  = mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 0);
    tv[6]  = mk(0, 4'hF, 4'hF, 0, 1, 4'h2, 1, 1);
    tv[7]  = mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 1);
    tv[8]  = mk(0, 4'hF, 4'hF, 0, 1, 4'h4, 1, 2);
    tv[9]  = mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 2);
    tv[10] = mk(0, 4'hF, 4'hF, 0, 1, 4'h8, 1, 3);
    tv[11] = mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 0, 3);
    tv[12] = mk(0, 4'hF, 4'hF, 0, 1, 4'h1, 1, 0);
    tv[13] = mk(0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0);

    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int k = 0; k < 14; k++) begin
      rst       = tv[k].r;
      req_valid = tv[k].v;
      req_last  = tv[k].l;
      fifo_full = tv[k].f;
      if (tv[k].we) sbq.push_back(DW'(8'hA0 + tv[k].gid));
      tick();
      chk($sformatf("tv%0d_wr_en", k), int'(s_wr), int'(tv[k].we));
      chk($sformatf("tv%0d_ready", k), int'(s_ready), int'(tv[k].rdy));
      chk($sformatf("tv%0d_busy", k), int'(s_busy), int'(tv[k].bz));
      chk($sformatf("tv%0d_gid", k), s_gid, tv[k].gid);
    end
    chk("rr_sb_empty", sbq.size(), 0);

    prod_en = 1'b1;

    do_reset();
    rem[2] = 20;
    rem[3] = 1;
    uselast[3] = 1'b1;
    drive();
    for (int k = 0; k < 8; k++) sbq.push_back(word(2, k));
    sbq.push_back(word(3, 0));
    for (int k = 8; k < 20; k++) sbq.push_back(word(2, k));
    run_until_idle(100);
    chk("cap_ngrants", glog.size(), 4);
    chk("cap_nbursts", llog.size(), 4);
    if (glog.size() == 4 && llog.size() == 4) begin
      chk("cap_g0", glog[0], 2);
      chk("cap_g1", glog[1], 3);
      chk("cap_g2", glog[2], 2);
      chk("cap_g3", glog[3], 2);
      chk("cap_l0", llog[0], 8);
      chk("cap_l1", llog[1], 1);
      chk("cap_l2", llog[2], 8);
      chk("cap_l3", llog[3], 4);
    end
    chk("cap_sb_empty", sbq.size(), 0);

    do_reset();
    rem[0] = 10;
    drive();
    for (int k = 0; k < 10; k++) sbq.push_back(word(0, k));
    tick();
    chk("stall_arb_busy", int'(s_busy), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pre_wr", int'(s_wr), 1);
    end
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_wr", int'(s_wr), 0);
      chk("stall_ready", int'(s_ready), 0);
      chk("stall_busy", int'(s_busy), 1);
    end
    fifo_full = 1'b0;
    run_until_idle(100);
    chk("stall_nbursts", llog.size(), 2);
    if (llog.size() == 2) begin
      chk("stall_l0", llog[0], 8);
      chk("stall_l1", llog[1], 2);
    end
    chk("stall_sb_empty", sbq.size(), 0);

    do_reset();
    rem[0] = 2;
    rem[1] = 1;
    uselast[1] = 1'b1;
    drive();
    sbq.push_back(word(0, 0));
    sbq.push_back(word(0, 1));
    sbq.push_back(word(1, 0));
    tick();
    chk("to_arb_busy", int'(s_busy), 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("to_beat_wr", int'(s_wr), 1);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("to_hold_busy", int'(s_busy), 1);
      chk("to_hold_wr", int'(s_wr), 0);
      chk("to_hold_gid", s_gid, 0);
    end
    tick();
    chk("to_release", int'(s_busy), 0);
    tick();
    chk("to_next_busy", int'(s_busy), 1);
    chk("to_next_gid", s_gid, 1);
    chk("to_next_wr", int'(s_wr), 1);
    tick();
    chk("to_end_busy", int'(s_busy), 0);
    chk("to_sb_empty", sbq.size(), 0);

    rem[3] = 10;
    drive();
    for (int k = 0; k < 5; k++) sbq.push_back(word(3, k));
    tick();
    chk("mr_arb_busy", int'(s_busy), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mr_beat_wr", int'(s_wr), 1);
      chk("mr_beat_gid", s_gid, 3);
    end
    rst = 1'b1;
    tick();
    chk("mr_rst_wr", int'(s_wr), 0);
    chk("mr_rst_ready", int'(s_ready), 0);
    chk("mr_rst_busy", int'(s_busy), 0);
    chk("mr_sb_five", sbq.size(), 0);
    rst = 1'b0;
    rem[3] = 1;
    uselast[3] = 1'b1;
    rem[1] = 1;
    drive();
    glog.delete();
    sbq.push_back(word(1, cnt[1]));
    sbq.push_back(word(3, cnt[3]));
    tick();
    chk("mr_post_busy", int'(s_busy), 0);
    chk("mr_post_gid", s_gid, 0);
    run_until_idle(50);
    chk("mr_ngrants", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("mr_g0", glog[0], 1);
      chk("mr_g1", glog[1], 3);
    end
    chk("mr_sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
